// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants
// and the baud divider helper used by both receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_t;

  // Rounded clocks per oversample tick, never below one.
  function automatic int uart_div(
    input int clk_hz,
    input int baud
  );
    int d;
    d = (clk_hz + (OVERSAMPLE * baud) / 2)
      / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO with first-word-fall-through output.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A full FIFO still accepts when the head leaves this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver, 8N1, with receive FIFO.
// Define UART_RX_PARITY_EN for an even parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] HALF_BIT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [1:0]           sync_q, sync_d;
  uart_rx_state_t       state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 bad_par_q, bad_par_d;
  logic                 perr_q, perr_d;
`endif

  logic tick;
  logic line;
  logic half;
  logic mid;
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign line = sync_q[1];
  assign half = tick && (scnt_q == HALF_BIT);
  assign mid  = tick && (scnt_q == FULL_BIT);

  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  assign sync_d     = {sync_q[0], serial_in};

  always_comb begin
    state_d = state_q;
    scnt_d  = tick ? scnt_q + SW'(1) : scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par_d = bad_par_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        scnt_d = '0;
        bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
        bad_par_d = 1'b0;
`endif
        if (!line) state_d = ST_START;
      end
      ST_START: begin
        if (half) begin
          scnt_d  = '0;
          state_d = line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (mid) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + BW'(1);
          if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (mid) begin
          bad_par_d = (^shift_q) != line;
          perr_d    = (^shift_q) != line;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (mid) begin
          if (line) begin
`ifdef UART_RX_PARITY_EN
            push = !bad_par_q;
`else
            push = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop   = rx_valid && rx_ready;
  assign ovr_d = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_par_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync_q     <= sync_d;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      bad_par_q  <= bad_par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (rx_data),
    .full  (full),
    .empty (empty)
  );

  assign rx_valid  = !empty;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
  assign busy = (state_q != ST_IDLE) && (state_q != ST_BREAK);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Expected bytes go to a scoreboard queue as frames are sent.
module tb_uart_rx;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DEPTH  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int rd_idx  = 0;
  int pop_cyc = 0;
  int fall_cyc = 0;
  int fcnt = 0;
  int ocnt = 0;
  int pcnt = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got.push_back(rx_data);
      pop_cyc <= cyc;
    end
    if (frame_err) fcnt <= fcnt + 1;
    if (overrun)   ocnt <= ocnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pcnt <= pcnt + 1;
`endif
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] want
  );
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop,
    input logic       par
  );
    serial_in = 1'b0;
    fall_cyc  = cyc;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      idle(16);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = par;
    idle(16);
`else
    if (par === 1'bx) serial_in = 1'b1;
`endif
    serial_in = stop;
    idle(16);
  endtask

  task automatic drain(input string tag);
    logic [31:0] a;
    while (exp_q.size() > 0) begin
      if (rd_idx < got.size()) begin
        a = {24'h0, got[rd_idx]};
        rd_idx++;
      end else begin
        a = 32'hDEAD_BEEF;
      end
      check({tag, "_byte"}, a,
            {24'h0, exp_q.pop_front()});
    end
    check({tag, "_extra"}, got.size() - rd_idx, 0);
    rd_idx = got.size();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         ferr;
  } vec_t;

  vec_t tbl[6];
  int   f0, o0, p0, lat;

  initial begin
    tbl[0] = '{8'hA3, 1'b1, 0};
    tbl[1] = '{8'h00, 1'b1, 0};
    tbl[2] = '{8'hFF, 1'b1, 0};
    tbl[3] = '{8'h80, 1'b0, 1};
    tbl[4] = '{8'h5A, 1'b1, 0};
    tbl[5] = '{8'h01, 1'b0, 1};

    serial_in = 1'b1;
    rx_ready  = 1'b1;
    rst_n     = 1'b0;
    idle(3);
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    idle(1);
    rst_n = 1'b1;
    idle(5);

    // single 0x55 with latency
    f0 = fcnt; o0 = ocnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, ^8'h55);
    idle(20);
    lat = pop_cyc - fall_cyc;
    check("lat55_in_window",
          {31'h0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 1);
    check("ferr55", fcnt - f0, 0);
    check("ovr55", ocnt - o0, 0);
    drain("b55");

    for (int i = 0; i < 6; i++) begin
      f0 = fcnt; o0 = ocnt;
      if (tbl[i].stop) exp_q.push_back(tbl[i].d);
      send_frame(tbl[i].d, tbl[i].stop, ^tbl[i].d);
      serial_in = 1'b1;
      idle(32);
      check($sformatf("tbl%0d_ferr", i),
            fcnt - f0, tbl[i].ferr);
      check($sformatf("tbl%0d_ovr", i), ocnt - o0, 0);
      drain($sformatf("tbl%0d", i));
    end

    // start-bit glitch is rejected
    serial_in = 1'b0;
    idle(4);
    serial_in = 1'b1;
    @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    idle(20);
    @(negedge clk);
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid", rx_valid, 0);

    // reset mid-frame
    f0 = fcnt;
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        idle(80);
        @(negedge clk);
        check("mid_busy", busy, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check("mid_ferr", fcnt - f0, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(20);
    drain("after_rst");

    // break: held low for 40 bit times
    f0 = fcnt;
    send_frame(8'hA3, 1'b0, ^8'hA3);
    idle(40 * 16);
    serial_in = 1'b1;
    idle(32);
    check("brk_ferr_once", fcnt - f0, 1);
    drain("brk");
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(20);
    drain("after_brk");

    // overrun on the fifth byte
    rx_ready = 1'b0;
    o0 = ocnt;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, ^(8'(i)));
    end
    idle(4);
    check("ovr_none_yet", ocnt - o0, 0);
    send_frame(8'h05, 1'b1, ^8'h05);
    idle(8);
    check("ovr_once", ocnt - o0, 1);
    @(negedge clk);
    check("ovr_head", rx_data, 8'h01);
    idle(1);
    rx_ready = 1'b1;
    idle(10);
    @(negedge clk);
    check("ovr_empty", rx_valid, 0);
    drain("ovr");

    // zero-gap frames, then push into full with pop
    rx_ready = 1'b0;
    o0 = ocnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    @(negedge clk);
    check("b2b_full_head", rx_data, 8'h00);
    idle(1);
    fork
      send_frame(8'h33, 1'b1, ^8'h33);
      begin
        idle(LAT - 1);
        rx_ready = 1'b1;
      end
    join
    idle(20);
    check("b2b_ovr", ocnt - o0, 0);
    drain("b2b");

`ifdef UART_RX_PARITY_EN
    p0 = pcnt; f0 = fcnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("par_bad_pulse", pcnt - p0, 1);
    check("par_bad_ferr", fcnt - f0, 0);
    drain("par_bad");
    p0 = pcnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_ok_pulse", pcnt - p0, 0);
    drain("par_ok");
`else
    p0 = pcnt;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
